// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared register-file constants, state type and address check
package reg_file_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int ADDR_W    = 32;
    localparam int REG_IDX_W = $clog2(NREG);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } rf_state_e;

    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(NREG);
    endfunction

endpackage

// File: rtl/reg_file_rf_read_port.sv
// rtl/reg_file_rf_read_port.sv - one combinational read port: range check, x0 zeroing, write bypass
module rf_read_port #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              run,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic [XLEN-1:0]   arr_data,
    output logic [XLEN-1:0]   rd_data,
    output logic              addr_err
);

    logic valid;
    logic is_zero;
    logic bypass_hit;

    assign valid      = rd_addr < ADDR_W'(NREG);
    assign is_zero    = (rd_addr == '0);
    assign bypass_hit = wr_en && (wr_addr == rd_addr);
    assign addr_err   = !valid;

    // Matching addresses imply wr_addr is also valid and non-zero once rd_addr passes both checks.
    always_comb begin
        rd_data = '0;
        if (run && valid && !is_zero) begin
            rd_data = bypass_hit ? wr_data : arr_data;
        end
    end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32-entry register file with post-reset clear sequencer and two bypassed read ports
module reg_file
    import reg_file_pkg::*;
#(
    parameter int XLEN   = reg_file_pkg::XLEN,
    parameter int NREG   = reg_file_pkg::NREG,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [XLEN-1:0]   rd_data1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [XLEN-1:0]   rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    output logic              init_busy,
    output logic              rd_addr_err,
    output logic              wr_err,
    output logic [31:0]       wr_count
);

    localparam int IDX_W = $clog2(NREG);

    rf_state_e        state_q;
    rf_state_e        state_d;
    logic [IDX_W-1:0] cnt_q;
    logic [XLEN-1:0]  regs [NREG];
    logic             run;
    logic             wr_addr_ok;
    logic             commit;
    logic             addr_err1;
    logic             addr_err2;

    assign run        = (state_q == ST_RUN);
    assign init_busy  = !run;
    assign wr_addr_ok = wr_addr < ADDR_W'(NREG);
    assign commit     = run && wr_en && wr_addr_ok && (wr_addr != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && cnt_q == IDX_W'(NREG - 1)) begin
            state_d = ST_RUN;
        end
    end

    // Storage has no reset; the INIT walk zeroes one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (!run) begin
            regs[cnt_q] <= '0;
        end else if (commit) begin
            regs[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_err   <= 1'b0;
            wr_count <= '0;
        end else begin
            if (commit) begin
                wr_count <= wr_count + 32'd1;
            end
            if (run && wr_en && !wr_addr_ok) begin
                wr_err <= 1'b1;
            end
        end
    end

    rf_read_port #(.XLEN(XLEN), .NREG(NREG), .ADDR_W(ADDR_W)) u_rd_port1 (
        .run      (run),
        .rd_addr  (rd_addr1),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .arr_data (regs[rd_addr1[IDX_W-1:0]]),
        .rd_data  (rd_data1),
        .addr_err (addr_err1)
    );

    rf_read_port #(.XLEN(XLEN), .NREG(NREG), .ADDR_W(ADDR_W)) u_rd_port2 (
        .run      (run),
        .rd_addr  (rd_addr2),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .arr_data (regs[rd_addr2[IDX_W-1:0]]),
        .rd_data  (rd_data2),
        .addr_err (addr_err2)
    );

    assign rd_addr_err = addr_err1 || addr_err2;

endmodule
